// File: rtl/digit_argmax_decoder.sv
// Serial argmax over one frame of signed class scores.
// Emits the winning class index, its score and a frame-length error flag.
module digit_argmax_decoder #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              score_valid,
    output logic              score_ready,
    input  logic [DATA_W-1:0] score_data,
    input  logic              score_last,
    output logic              class_valid,
    input  logic              class_ready,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] class_score,
    output logic              frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        HOLD
    } state_t;

    localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(NUM_CLASSES - 1);
    localparam logic [IDX_W:0] ONE_CNT  = (IDX_W+1)'(1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W:0]    count_q, count_d;
    logic              err_q, err_d;
    logic              beat;

    assign score_ready = ~rst & (state_q != HOLD);
    assign beat        = score_valid & score_ready;

    // NOTE: every next-state signal gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        idx_d   = idx_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (beat) begin
                    max_d   = score_data;
                    idx_d   = '0;
                    count_d = ONE_CNT;
                    // A frame of one beat is always short since NUM_CLASSES >= 2.
                    err_d   = score_last;
                    state_d = score_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    if ($signed(score_data) > $signed(max_q)) begin
                        max_d = score_data;
                        idx_d = count_q[IDX_W-1:0];
                    end
                    count_d = count_q + ONE_CNT;
                    if (score_last) begin
                        err_d   = (count_q != LAST_CNT);
                        state_d = HOLD;
                    end else if (count_q == LAST_CNT) begin
                        // Long frame: discard the remainder up to score_last.
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (beat && score_last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (class_ready) begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            max_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign class_valid = (state_q == HOLD);
    assign class_idx   = idx_q;
    assign class_score = max_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_digit_argmax_decoder.sv
// Directed self-checking bench for digit_argmax_decoder.
// Each frame's expected winner is hand-computed from its score list.
module tb_digit_argmax_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        score_valid;
    logic        score_ready;
    logic [31:0] score_data;
    logic        score_last;
    logic        class_valid;
    logic        class_ready;
    logic [3:0]  class_idx;
    logic [31:0] class_score;
    logic        frame_err;

    int n_vec = 0;
    int n_err = 0;
    int fr[16];

    digit_argmax_decoder #(
        .NUM_CLASSES(10),
        .DATA_W     (32),
        .IDX_W      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .score_valid(score_valid),
        .score_ready(score_ready),
        .score_data (score_data),
        .score_last (score_last),
        .class_valid(class_valid),
        .class_ready(class_ready),
        .class_idx  (class_idx),
        .class_score(class_score),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive fr[0..n-1] one beat per cycle; score_last on the final beat if do_last.
    task automatic send_beats(input int n, input bit do_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            score_valid = 1'b1;
            score_data  = fr[i];
            score_last  = do_last && (i == n - 1);
            for (int w = 0; w < 20 && !score_ready; w++) @(negedge clk);
            check("beat_ready", {31'b0, score_ready}, 32'd1);
        end
        @(posedge clk);
        #1;
        score_valid = 1'b0;
        score_last  = 1'b0;
    endtask

    // Called #1 after the edge that took the last beat; optionally stalls in HOLD.
    task automatic get_result(input string tag, input int e_idx, input int e_score,
                              input bit e_err, input int stall);
        check({tag, "_valid"}, {31'b0, class_valid}, 32'd1);
        check({tag, "_idx"},   {28'b0, class_idx},   e_idx);
        check({tag, "_score"}, class_score,          e_score);
        check({tag, "_err"},   {31'b0, frame_err},   {31'b0, e_err});
        for (int c = 0; c < stall; c++) begin
            @(negedge clk);
            score_valid = 1'b1;
            score_data  = 32'd1000;
            score_last  = 1'b1;
            check({tag, "_stall_valid"}, {31'b0, class_valid}, 32'd1);
            check({tag, "_stall_ready"}, {31'b0, score_ready}, 32'd0);
            check({tag, "_stall_idx"},   {28'b0, class_idx},   e_idx);
            check({tag, "_stall_score"}, class_score,          e_score);
        end
        @(negedge clk);
        score_valid = 1'b0;
        score_last  = 1'b0;
        class_ready = 1'b1;
        @(posedge clk);
        #1;
        class_ready = 1'b0;
        check({tag, "_released"}, {31'b0, class_valid}, 32'd0);
        check({tag, "_rdy_again"}, {31'b0, score_ready}, 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        score_valid = 1'b0;
        score_data  = '0;
        score_last  = 1'b0;
        class_ready = 1'b0;
        #12;
        check("rst_ready", {31'b0, score_ready}, 32'd0);
        check("rst_valid", {31'b0, class_valid}, 32'd0);
        check("rst_idx",   {28'b0, class_idx},   32'd0);
        check("rst_score", class_score,          32'd0);
        check("rst_err",   {31'b0, frame_err},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_ready", {31'b0, score_ready}, 32'd1);

        // Tie at index 7 loses to index 4.
        fr = '{3, -1, 7, 2, 9, 0, 4, 9, 1, 5, 0, 0, 0, 0, 0, 0};
        send_beats(10, 1'b1);
        get_result("t1", 4, 9, 1'b0, 0);

        fr = '{-5, -5, -5, -5, -5, -5, -5, -5, -5, -5, 0, 0, 0, 0, 0, 0};
        send_beats(10, 1'b1);
        get_result("t2_eq", 0, -5, 1'b0, 0);

        // Signed compare: 1 beats the most negative value that follows it.
        for (int i = 0; i < 16; i++) fr[i] = 32'h8000_0000;
        fr[0] = 1;
        send_beats(10, 1'b1);
        get_result("t2_min", 0, 1, 1'b0, 0);

        fr[0] = 32'h8000_0000;
        fr[6] = -3;
        send_beats(10, 1'b1);
        get_result("t2_neg", 6, -3, 1'b0, 0);

        fr = '{2, 4, 6, 8, 1, 3, 5, 7, 9, 0, 0, 0, 0, 0, 0, 0};
        send_beats(10, 1'b1);
        get_result("t3", 8, 9, 1'b0, 5);

        fr = '{1, 8, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_beats(4, 1'b1);
        get_result("t4", 1, 8, 1'b1, 0);

        // Beats 11-12 (including the 20) fall in the drained tail.
        fr = '{0, 1, 6, 2, 3, 4, 5, 1, 0, 2, 20, 3, 0, 0, 0, 0};
        send_beats(12, 1'b1);
        get_result("t5", 2, 6, 1'b1, 0);

        fr = '{1, 2, 100, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_beats(5, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_ready", {31'b0, score_ready}, 32'd0);
        check("t6_rst_valid", {31'b0, class_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        fr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 50, 0, 0, 0, 0, 0, 0};
        send_beats(10, 1'b1);
        get_result("t6", 9, 50, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
